mic_pair_angle_sched: RTL
=========================

// Module: mic_pair_angle_sched
// PURPOSE
//  Round-robin scheduler sharing one angle engine (lag -> ROM acos -> 16-avg) among
//  NUM_PAIRS microphone pairs. Latches each pair's lag request and drives the engine's
//  ena/lag_diff burst until its done pulse. Tags the averaged angle with the pair ID.
//  Sits between the per-pair cross-correlation lag finders and the position solver.
// PARAMETERS
//  NUM_PAIRS    4      number of requesting mic pairs (2..8)
//  ID_W         3      width of pair index (>= clog2(NUM_PAIRS))
//  TIMEOUT_CYC  4096   max cycles in WAIT before abort (12-bit counter)
// PORTS
//  clk_60MHz   in   1            system clock
//  rst_n       in   1            async active-low reset
//  req         in   NUM_PAIRS    per-pair request level, held until grant
//  lag_in      in   6*NUM_PAIRS  signed lag per pair; pair k at [6k+5:6k]
//  grant       out  NUM_PAIRS    one-hot 1-cycle accept pulse
//  eng_ena     out  1            engine enable (held high during burst)
//  eng_lag     out  6            signed lag driven to engine
//  eng_done    in   1            engine 1-cycle completion pulse
//  eng_angle   in   16           engine averaged angle (valid when eng_done)
//  res_valid   out  1            1-cycle result strobe
//  res_id      out  ID_W         pair index of result
//  res_angle   out  16           signed result angle
//  timeout_err out  1            sticky; set on WAIT timeout, cleared by reset only
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0; grant, eng_ena, eng_lag, res_valid, res_id,
//   res_angle, timeout_err all 0.
//  IDLE: scan req from rr_ptr upward, wrapping at NUM_PAIRS-1 -> 0; first set bit k wins.
//   On win: grant[k]=1 for 1 cycle, latch lag_in[k] and cur_id=k, -> ISSUE. None set: stay.
//  ISSUE (1 cycle): eng_ena=1, eng_lag=latched lag, timeout cnt=0 -> WAIT.
//  WAIT: eng_ena held 1, eng_lag stable; cnt++ each cycle.
//   eng_done=1 -> capture eng_angle -> POST (done has priority over timeout same cycle).
//   cnt==TIMEOUT_CYC-1 without done -> eng_ena=0, timeout_err=1, no res_valid,
//   rr_ptr=(cur_id+1) mod NUM_PAIRS -> IDLE.
//  POST (1 cycle): eng_ena=0; res_valid=1, res_id=cur_id, res_angle=captured value;
//   rr_ptr=(cur_id+1) mod NUM_PAIRS -> IDLE. res_id/res_angle hold until next POST.
//  Latency: req->grant 1 cycle from IDLE; eng_done->res_valid 1 cycle.
//  eng_done outside WAIT ignored. req changes after grant ignored (lag already latched).
//  Requester must drop req the cycle after grant, else re-arbitrated next IDLE scan
//   (fairness still holds: rr_ptr has moved past it).
//  Back-to-back: min 4 cycles grant-to-grant; no request starves (max wait NUM_PAIRS jobs).
//  Reset mid-burst: eng_ena drops immediately (async), job discarded, no res_valid.
//  eng_lag driven 0 whenever eng_ena=0.
// CONFIGURATION
//  ANGLE_SIGN_EN defined: lag sign applied to result: latched lag<0 ->
//   res_angle = -eng_angle (16-bit two's complement); lag>=0 -> unchanged.
//  Undefined: res_angle = eng_angle unmodified (engine magnitude only).
//  Sign uses latched lag, not live lag_in.
// TESTING
//  Reset: assert rst_n=0 during WAIT -> eng_ena, grant, res_valid=0 same cycle; state IDLE.
//  Single: req=4'b0100, lag=+5; engine done after 20 cyc with 0x0123 ->
//   grant=4'b0100, res_valid 1 cyc, res_id=2, res_angle=0x0123.
//  Fairness: req=4'b1111 held, engine done after 10 cyc each -> grant order
//   0,1,2,3,0 and res_id order matches.
//  Timeout: TIMEOUT_CYC=16, never pulse eng_done -> eng_ena low at 16th WAIT cycle,
//   timeout_err=1 sticky, no res_valid, next grant goes to cur_id+1.
//  Sign: lag=-3, eng_angle=0x0050 -> res_angle=0xFFB0 with ANGLE_SIGN_EN, 0x0050 without.
//  Race: eng_done on the same cycle cnt reaches TIMEOUT_CYC-1 -> result delivered,
//   timeout_err stays 0.

Source files
------------

// File: rtl/mic_pair_angle_sched.sv
// Round-robin scheduler sharing one lag->angle engine among NUM_PAIRS mic pairs.
// Optional `ANGLE_SIGN_EN: negate the result angle when the latched lag is negative.
//   state | meaning
//   IDLE  | scan requests from rr_ptr, grant first found
//   ISSUE | grant pulse, engine burst starts, timeout count cleared
//   WAIT  | engine busy; done captures angle, count expiry aborts
//   POST  | result strobe, round-robin pointer advanced
module mic_pair_angle_sched #(
  parameter int NUM_PAIRS   = 4,
  parameter int ID_W        = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk_60MHz,
  input  logic                   rst_n,
  input  logic [NUM_PAIRS-1:0]   req,
  input  logic [6*NUM_PAIRS-1:0] lag_in,
  output logic [NUM_PAIRS-1:0]   grant,
  output logic                   eng_ena,
  output logic [5:0]             eng_lag,
  input  logic                   eng_done,
  input  logic [15:0]            eng_angle,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [15:0]            res_angle,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_POST} state_t;

  localparam logic [11:0]          CNT_LAST = 12'(TIMEOUT_CYC - 1);
  localparam logic [NUM_PAIRS-1:0] ONE_HOT0 = NUM_PAIRS'(1);

  state_t                 state, state_d;
  logic [ID_W-1:0]        rr_ptr, cur_id, win_id, next_ptr;
  logic                   found;
  logic [5:0]             lag_q;
  logic [11:0]            cnt;
  logic [15:0]            angle_adj;
  logic [NUM_PAIRS-1:0]   req_sh;
  logic [6*NUM_PAIRS-1:0] lag_sh;
  int                     idx;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    req_sh = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PAIRS) idx = idx - NUM_PAIRS;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  assign lag_sh   = lag_in >> (6 * int'(win_id));
  assign next_ptr = (int'(cur_id) == NUM_PAIRS - 1) ? '0 : cur_id + 1'b1;

`ifdef ANGLE_SIGN_EN
  // sign comes from the latched lag so late lag_in changes cannot flip it
  assign angle_adj = lag_q[5] ? (~eng_angle + 16'd1) : eng_angle;
`else
  assign angle_adj = eng_angle;
`endif

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    grant     = '0;
    eng_ena   = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: begin
        grant   = ONE_HOT0 << cur_id;
        eng_ena = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        eng_ena = 1'b1;
        if (eng_done)             state_d = S_POST;
        else if (cnt == CNT_LAST) state_d = S_IDLE;
      end
      S_POST: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decode straight from state so an async reset kills the burst at once
  assign eng_lag = eng_ena ? lag_q : 6'd0;

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cur_id      <= '0;
      lag_q       <= '0;
      cnt         <= '0;
      res_id      <= '0;
      res_angle   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          cur_id <= win_id;
          lag_q  <= lag_sh[5:0];
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 12'd1;
          if (eng_done) begin
            res_id    <= cur_id;
            res_angle <= angle_adj;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
          end
        end
        S_POST: rr_ptr <= next_ptr;
        default: ;
      endcase
    end
  end

endmodule
